// File: rtl/iqueue_ring.sv
// rtl/iqueue_ring.sv - circular instruction queue between fetch aligner and decode/issue
//
// Accepts a group of up to FETCH_W aligned {PC, instr} entries per cycle (all-or-nothing)
// and presents the ISSUE_W oldest entries to issue with a thermometer valid mask.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   i_flush      synchronous flush (branch redirect), highest priority
//   i_enq_valid  enqueue group present
//   i_enq_cnt    entries in the group, slot 0 oldest
//   i_enq_data   group payload, slot k at [k*ENTRY_W +: ENTRY_W]
//   o_enq_ready  group fits in current room and is a legal size
//   o_room       free entries
//   o_count      occupied entries
//   o_deq_valid  per-slot valid mask, thermometer from bit 0
//   o_deq_data   slot k = entry at head+k
//   i_deq_ready  issue consumes every valid slot this cycle
//   o_err        sticky: oversize group was presented
module iqueue_ring #(
    parameter int ENTRY_W = 64,
    parameter int FETCH_W = 10,
    parameter int ISSUE_W = 4,
    parameter int DEPTH   = 16,
    parameter int PARTIAL = 1,
    parameter int NOP_PAD = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_flush,
    input  logic                           i_enq_valid,
    input  logic [$clog2(FETCH_W+1)-1:0]   i_enq_cnt,
    input  logic [FETCH_W*ENTRY_W-1:0]     i_enq_data,
    output logic                           o_enq_ready,
    output logic [$clog2(DEPTH+1)-1:0]     o_room,
    output logic [$clog2(DEPTH+1)-1:0]     o_count,
    output logic [ISSUE_W-1:0]             o_deq_valid,
    output logic [ISSUE_W*ENTRY_W-1:0]     o_deq_data,
    input  logic                           i_deq_ready,
    output logic                           o_err
);

    localparam int CNT_W = $clog2(FETCH_W + 1);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int XW    = ((CNT_W > CW) ? CNT_W : CW) + 1;

    localparam logic [ENTRY_W-1:0] PAD = (NOP_PAD != 0) ? ENTRY_W'(32'h0000_0013) : '0;

    // Every step is at most DEPTH, so one conditional subtract brings the
    // one-bit-wider sum back into 0..DEPTH-1 for any DEPTH, power of two or not.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input logic [PW:0] inc);
        logic [PW:0] sum;
        sum = {1'b0, base} + inc;
        if (sum >= (PW+1)'(DEPTH))
            sum = sum - (PW+1)'(DEPTH);
        return sum[PW-1:0];
    endfunction

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;
    logic [CW-1:0]      count;
    logic [CW-1:0]      room;
    logic               err;

    logic               cnt_legal;
    logic               cnt_fits;
    logic               enq_fire;
    logic               deq_fire;
    logic               full_grp;
    logic [CW-1:0]      avail;
    logic [CW-1:0]      enq_n;
    logic [CW-1:0]      deq_n;
    logic [CW-1:0]      count_nxt;
    logic [PW-1:0]      head_nxt;
    logic [PW-1:0]      tail_nxt;

    assign o_room  = room;
    assign o_count = count;
    assign o_err   = err;

    // Readiness looks only at registered room, so space freed by a same-cycle
    // dequeue is never handed to the enqueue side.
    always_comb begin
        cnt_legal   = XW'(i_enq_cnt) <= XW'(FETCH_W);
        cnt_fits    = XW'(i_enq_cnt) <= XW'(room);
        o_enq_ready = cnt_legal && cnt_fits;
        enq_fire    = i_enq_valid && o_enq_ready && !i_flush && (i_enq_cnt != '0);
    end

    always_comb begin
        full_grp    = count >= CW'(ISSUE_W);
        avail       = full_grp ? CW'(ISSUE_W) : count;
        o_deq_valid = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            if (PARTIAL != 0)
                o_deq_valid[k] = CW'(k) < avail;
            else
                o_deq_valid[k] = full_grp;
        end
        deq_fire = i_deq_ready && (o_deq_valid != '0);
    end

    always_comb begin
        o_deq_data = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            if (o_deq_valid[k])
                o_deq_data[k*ENTRY_W +: ENTRY_W] = mem[wrap_add(head, (PW+1)'(k))];
            else
                o_deq_data[k*ENTRY_W +: ENTRY_W] = PAD;
        end
    end

    always_comb begin
        enq_n = enq_fire ? CW'(i_enq_cnt) : '0;
        if (!deq_fire)
            deq_n = '0;
        else if (PARTIAL != 0)
            deq_n = avail;
        else
            deq_n = CW'(ISSUE_W);
        count_nxt = count + enq_n - deq_n;
        head_nxt  = wrap_add(head, (PW+1)'(deq_n));
        tail_nxt  = wrap_add(tail, (PW+1)'(enq_n));
    end

    // Storage carries no reset; only slots below count are ever presented.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            for (int k = 0; k < FETCH_W; k++) begin
                if (CNT_W'(k) < i_enq_cnt)
                    mem[wrap_add(tail, (PW+1)'(k))] <= i_enq_data[k*ENTRY_W +: ENTRY_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            room  <= CW'(DEPTH);
            err   <= 1'b0;
        end else begin
            if (i_enq_valid && !cnt_legal)
                err <= 1'b1;
            if (i_flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                room  <= CW'(DEPTH);
            end else begin
                head  <= head_nxt;
                tail  <= tail_nxt;
                count <= count_nxt;
                room  <= CW'(DEPTH) - count_nxt;
            end
        end
    end

endmodule

// File: tb/tb_iqueue_ring.sv
// tb/tb_iqueue_ring.sv - scoreboard bench for iqueue_ring (DEPTH 16 partial/NOP, DEPTH 13 full-group/zero pad)
module tb_iqueue_ring;

    localparam int EW = 64;
    localparam int FW = 10;
    localparam int IW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                fl    [2];
    logic                ev    [2];
    logic                rdy   [2];
    logic [3:0]          ecnt  [2];
    logic [FW*EW-1:0]    edata [2];
    logic                erdy  [2];
    logic [IW-1:0]       dv    [2];
    logic [IW*EW-1:0]    dq    [2];
    logic                err   [2];
    logic [4:0]          cnt0, room0;
    logic [3:0]          cnt1, room1;

    iqueue_ring #(.ENTRY_W(EW), .FETCH_W(FW), .ISSUE_W(IW), .DEPTH(16), .PARTIAL(1), .NOP_PAD(1)) u_a (
        .clk(clk), .rst(rst), .i_flush(fl[0]), .i_enq_valid(ev[0]), .i_enq_cnt(ecnt[0]),
        .i_enq_data(edata[0]), .o_enq_ready(erdy[0]), .o_room(room0), .o_count(cnt0),
        .o_deq_valid(dv[0]), .o_deq_data(dq[0]), .i_deq_ready(rdy[0]), .o_err(err[0])
    );

    iqueue_ring #(.ENTRY_W(EW), .FETCH_W(FW), .ISSUE_W(IW), .DEPTH(13), .PARTIAL(0), .NOP_PAD(0)) u_b (
        .clk(clk), .rst(rst), .i_flush(fl[1]), .i_enq_valid(ev[1]), .i_enq_cnt(ecnt[1]),
        .i_enq_data(edata[1]), .o_enq_ready(erdy[1]), .o_room(room1), .o_count(cnt1),
        .o_deq_valid(dv[1]), .o_deq_data(dq[1]), .i_deq_ready(rdy[1]), .o_err(err[1])
    );

    // Reference model: one FIFO of entries per instance plus flags.
    logic [63:0] exp_q [2][$];
    int  pend_seq [2];
    int  pend_n   [2];
    bit  pend_fl  [2];
    bit  pend_err [2];
    bit  err_m    [2];
    bit  exp_rdy  [2];
    bit  acc_last [2];
    int  seq      [2];

    bit  w_v   [2];
    bit  w_fl  [2];
    bit  w_rdy [2];
    int  w_cnt [2];

    int  n_checks = 0;
    int  n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int depth_of(input int d);
        return (d == 0) ? 16 : 13;
    endfunction

    function automatic int count_of(input int d);
        return (d == 0) ? int'(cnt0) : int'(cnt1);
    endfunction

    function automatic int room_of(input int d);
        return (d == 0) ? int'(room0) : int'(room1);
    endfunction

    function automatic logic [63:0] entry(input int d, input int i);
        logic [31:0] pc;
        logic [31:0] ins;
        pc  = 32'h100 + 32'(4 * i);
        ins = (32'(i) * 32'h9E37_79B1) ^ 32'(d + 1);
        return {pc, ins};
    endfunction

    // Drive one instance from the wanted values and record what the model expects.
    task automatic apply(input int d);
        int c;
        int n;
        c = w_cnt[d];
        n = exp_q[d].size();
        fl[d]   = w_fl[d];
        ev[d]   = w_v[d];
        rdy[d]  = w_rdy[d];
        ecnt[d] = 4'(c);
        for (int k = 0; k < FW; k++)
            edata[d][k*EW +: EW] = (k < c) ? entry(d, seq[d] + k) : {$urandom, $urandom};
        exp_rdy[d]  = (c <= FW) && (c <= depth_of(d) - n);
        acc_last[d] = rst && w_v[d] && !w_fl[d] && (c != 0) && exp_rdy[d];
        pend_fl[d]  = w_fl[d];
        pend_err[d] = rst && w_v[d] && (c > FW);
        pend_seq[d] = seq[d];
        pend_n[d]   = acc_last[d] ? c : 0;
        if (acc_last[d])
            seq[d] += c;
    endtask

    task automatic tick();
        @(negedge clk);
        apply(0);
        apply(1);
    endtask

    task automatic mon(input int d);
        int n;
        int av;
        logic [IW-1:0] m;
        logic [63:0] pad;
        logic [63:0] e;
        n   = exp_q[d].size();
        av  = (n < IW) ? n : IW;
        if (d == 0)
            m = IW'((1 << av) - 1);
        else
            m = (n >= IW) ? '1 : '0;
        pad = (d == 0) ? 64'h13 : 64'h0;
        chk($sformatf("d%0d count", d), 64'(count_of(d)), 64'(n));
        chk($sformatf("d%0d room", d), 64'(room_of(d)), 64'(depth_of(d) - n));
        chk($sformatf("d%0d deq_valid", d), 64'(dv[d]), 64'(m));
        chk($sformatf("d%0d enq_ready", d), 64'(erdy[d]), 64'(exp_rdy[d]));
        chk($sformatf("d%0d err", d), 64'(err[d]), 64'(err_m[d]));
        for (int k = 0; k < IW; k++) begin
            if (m[k])
                e = exp_q[d][k];
            else
                e = pad;
            chk($sformatf("d%0d slot%0d", d, k), dq[d][k*EW +: EW], e);
        end
        if (!rst) begin
            exp_q[d].delete();
            err_m[d] = 1'b0;
        end else begin
            if (pend_err[d])
                err_m[d] = 1'b1;
            if (pend_fl[d]) begin
                exp_q[d].delete();
            end else begin
                if (rdy[d] && m != '0)
                    for (int k = 0; k < $countones(m); k++)
                        void'(exp_q[d].pop_front());
                for (int k = 0; k < pend_n[d]; k++)
                    exp_q[d].push_back(entry(d, pend_seq[d] + k));
            end
        end
    endtask

    always @(negedge clk) begin
        #2;
        for (int d = 0; d < 2; d++)
            mon(d);
    end

    initial begin
        bit done;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            w_v[d] = 0; w_fl[d] = 0; w_rdy[d] = 0; w_cnt[d] = 0; seq[d] = 0; err_m[d] = 0;
            apply(d);
        end
        repeat (2) tick();

        // First group, presented across reset release.
        w_v[0] = 1; w_cnt[0] = 3; w_rdy[0] = 1;
        w_v[1] = 1; w_cnt[1] = 3; w_rdy[1] = 1;
        @(negedge clk);
        rst = 1'b1;
        apply(0);
        apply(1);

        w_v[0] = 0; w_cnt[0] = 0;
        w_cnt[1] = 1;
        tick();
        #3;
        chk("t1 mask", 64'(dv[0]), 64'(4'b0111));
        chk("t1 slot3 nop", dq[0][3*EW +: EW], {32'h0, 32'h13});
        chk("t1 slot0 pc", 64'(dq[0][63:32]), 64'h100);
        chk("p0 count3 mask", 64'(dv[1]), 64'h0);

        w_v[1] = 0; w_cnt[1] = 0;
        tick();
        #3;
        chk("t1 drained", 64'(cnt0), 64'h0);
        chk("p0 full mask", 64'(dv[1]), 64'(4'b1111));

        w_v[1] = 1; w_cnt[1] = 11;
        tick();
        w_v[1] = 0; w_cnt[1] = 0;
        tick();
        #3;
        chk("err set", 64'(err[1]), 64'h1);
        repeat (3) tick();
        #3;
        chk("err sticky", 64'(err[1]), 64'h1);

        // Stall of a second 10-entry group, then release by dequeuing.
        w_rdy[0] = 0; w_v[0] = 1; w_cnt[0] = 10;
        tick();
        tick();
        #3;
        chk("stall room", 64'(room0), 64'd6);
        chk("stall ready", 64'(erdy[0]), 64'h0);
        w_rdy[0] = 1;
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            tick();
            if (acc_last[0])
                done = 1;
        end
        chk("stall accept", 64'(done), 64'h1);
        w_v[0] = 0; w_cnt[0] = 0;
        repeat (6) tick();

        // Full queue: enqueue refused while a dequeue frees space.
        w_rdy[0] = 0; w_v[0] = 1; w_cnt[0] = 10;
        tick();
        w_cnt[0] = 6;
        tick();
        w_cnt[0] = 1; w_rdy[0] = 1;
        tick();
        #3;
        chk("full ready", 64'(erdy[0]), 64'h0);
        w_v[0] = 0; w_cnt[0] = 0; w_rdy[0] = 0;
        tick();
        #3;
        chk("full count", 64'(cnt0), 64'd12);

        // Flush beats a same-cycle enqueue and dequeue.
        w_v[0] = 1; w_cnt[0] = 2; w_rdy[0] = 1; w_fl[0] = 1;
        tick();
        w_v[0] = 0; w_cnt[0] = 0; w_fl[0] = 0;
        tick();
        #3;
        chk("flush count", 64'(cnt0), 64'h0);
        chk("flush room", 64'(room0), 64'd16);
        chk("flush mask", 64'(dv[0]), 64'h0);

        // Random traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < 2; d++) begin
                w_v[d]   = $urandom_range(0, 3) != 0;
                w_cnt[d] = ($urandom_range(0, 19) == 0) ? int'($urandom_range(11, 15)) : int'($urandom_range(0, FW));
                w_fl[d]  = $urandom_range(0, 29) == 0;
                w_rdy[d] = $urandom_range(0, 2) != 0;
            end
            tick();
        end
        for (int d = 0; d < 2; d++) begin
            w_v[d] = 0; w_cnt[d] = 0; w_fl[d] = 0; w_rdy[d] = 1;
        end
        repeat (8) tick();
        #4;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/iqueue_ring.md
# iqueue_ring

Parametrised, clocked instruction queue between the fetch aligner and the decode/issue stage. It accepts a variable-length group of aligned {PC, instruction} entries per cycle into a circular buffer. It presents up to ISSUE_W oldest entries per cycle to issue, with per-slot valid bits and optional NOP padding of partial groups. It adds backpressure, occupancy reporting, wrap-around storage and a synchronous flush for redirects.

## Interface
- ENTRY_W, 64: bits per entry, {PC[63:32], instr[31:0]}.
- FETCH_W, 10: max entries enqueued per cycle.
- ISSUE_W, 4: entries presented/dequeued per cycle.
- DEPTH, 16: storage entries; DEPTH ≥ FETCH_W and DEPTH ≥ ISSUE_W; any integer, not required to be a power of two.
- PARTIAL, 1: 1 = issue groups smaller than ISSUE_W; 0 = issue only when count ≥ ISSUE_W.
- NOP_PAD, 1: 1 = invalid output slots carry {32'h0, 32'h00000013}; 0 = invalid slots are all-zero.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low.
- i_flush  in  1  synchronous flush (branch redirect).
- i_enq_valid  in  1  enqueue group present.
- i_enq_cnt  in  $clog2(FETCH_W+1)  entries in group; slots 0..cnt-1 valid, slot 0 oldest.
- i_enq_data  in  FETCH_W*ENTRY_W  slot k at bits [k*ENTRY_W +: ENTRY_W].
- o_enq_ready  out  1  combinational: i_enq_cnt ≤ room && i_enq_cnt ≤ FETCH_W.
- o_room  out  $clog2(DEPTH+1)  free entries, registered.
- o_count  out  $clog2(DEPTH+1)  occupied entries, registered.
- o_deq_valid  out  ISSUE_W  per-slot valid mask, thermometer from bit 0.
- o_deq_data  out  ISSUE_W*ENTRY_W  slot k = entry at head+k (mod DEPTH).
- i_deq_ready  in  1  issue consumes all valid slots this cycle.
- o_err  out  1  sticky: enqueue attempted with i_enq_cnt > FETCH_W.

## Operation
- State: storage array, head, tail (0..DEPTH-1), count. room = DEPTH - count.
- Enqueue fires when i_enq_valid && o_enq_ready && !i_flush && i_enq_cnt ≠ 0.
  - Entries are written at tail+k mod DEPTH for k < i_enq_cnt.
  - tail advances by i_enq_cnt mod DEPTH.
- Enqueue is all-or-nothing; there is no partial accept. A group that does not fit waits; the upstream holds its data.
- Output mask: avail = min(count, ISSUE_W).
  - PARTIAL=1: o_deq_valid[k] = (k < avail).
  - PARTIAL=0: all ones if count ≥ ISSUE_W, else zero.
- Dequeue fires when i_deq_ready && o_deq_valid ≠ 0. head advances by popcount(o_deq_valid) mod DEPTH.
- Simultaneous enqueue and dequeue both take effect: count' = count + enq_n - deq_n.
  - Enqueue acceptance uses room at cycle start; space freed by a same-cycle dequeue is not reused.
- Flush has priority over everything. On the next edge head = tail = count = 0; the same-cycle enqueue and dequeue are dropped; storage contents are don't-care.
- o_err sets on i_enq_valid && i_enq_cnt > FETCH_W; that group is never accepted. o_err clears only on reset.
- Pointer arithmetic: sum computed one bit wider, then a single conditional subtract of DEPTH (valid since each step ≤ DEPTH).

## Timing
- Reset (rst low, asynchronous): count 0, head 0, tail 0, o_room DEPTH, o_count 0, o_deq_valid 0, o_err 0. o_deq_data is all NOP (NOP_PAD=1) or zero.
- Enqueue-to-output latency is 1 cycle. Data accepted at edge N appears on o_deq_data after edge N; there is no same-cycle bypass.
- o_deq_data and o_deq_valid are combinational from registered state only: head, count and storage.
- o_enq_ready depends combinationally on i_enq_cnt and registered room. It must not depend on i_deq_ready.
- Full (room=0): o_enq_ready=1 only for i_enq_cnt=0. Empty: o_deq_valid=0 and all slots padded.
- Reset release mid-stream: the first accepted enqueue is on the first rising edge with rst high.

## Test plan
- Reset, enqueue cnt=3 entries with PC 0x100/0x104/0x108, i_deq_ready=1, PARTIAL=1 → next cycle o_deq_valid=4'b0111, slot 3 = {0,0x13}; following cycle count=0.
- DEPTH=16: enqueue 10, then 10 again with no dequeue → second group stalls (room=6, o_enq_ready=0). Dequeue 4 per cycle → the group is accepted once room ≥ 10, and order is preserved across wrap.
- Non-power-of-2 DEPTH=13: run 200 random enqueue/dequeue cycles against a reference model → identical output order, count never exceeds 13.
- Simultaneous: count=16 (full), enqueue cnt=1 plus dequeue 4 in the same cycle → enqueue refused, count becomes 12.
- Flush with valid enqueue and dequeue in the same cycle → next cycle count=0, o_room=DEPTH, o_deq_valid=0.
- PARTIAL=0, count=3 → o_deq_valid=0. Enqueue 1 more → next cycle o_deq_valid=4'b1111. Separately, i_enq_cnt=11 → o_err=1 and stays 1.
